// File: rtl/tx_serializer_10b.sv
`timescale 1ns/1ps
// tx_serializer_10b
// Serialises 10-bit 8b/10b symbols onto the line, one bit per clock.
// Each slot is exactly ten cycles long. The slot carries the symbol waiting
// in a single-entry holding register or, if nothing is waiting, a K28.5 comma.
// The comma variant is chosen from the running disparity of the transmitted
// stream.
module tx_serializer_10b #(
   parameter logic [9:0] COMMA_NEG = 10'b0011111010,
   parameter logic [9:0] COMMA_POS = 10'b1100000101,
   parameter bit         MSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] sym_in,
   input  logic       sym_valid,
   output logic       sym_ready,
   output logic       tx_serial,
   output logic       tx_sym_start,
   output logic       idle_active,
   output logic       rd_pos,
   output logic       sym_err
);

   logic [9:0] shreg;
   logic [3:0] bit_cnt;
   logic [9:0] hold;
   logic       hold_full;
   logic       rd;

   logic       boundary;
   logic       accept;
   logic [9:0] load_sym;
   logic [3:0] load_ones;
   logic       rd_next;
   logic       load_bad;

   function automatic logic [3:0] ones_count(input logic [9:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 10; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   assign boundary  = (bit_cnt == 4'd9);
   assign sym_ready = ~hold_full;
   assign accept    = sym_valid & sym_ready;
   assign load_sym  = hold_full ? hold : (rd ? COMMA_POS : COMMA_NEG);
   assign load_ones = ones_count(load_sym);
   assign tx_serial = MSB_FIRST ? shreg[9] : shreg[0];
   assign rd_pos    = rd;

   // Classify the symbol being loaded: 6 ones flips disparity positive, 4 negative, 5 keeps it, anything else is illegal
   always_comb begin
      rd_next  = rd;
      load_bad = 1'b0;
      case (load_ones)
         4'd6:    rd_next = 1'b1;
         4'd4:    rd_next = 1'b0;
         4'd5:    rd_next = rd;
         default: load_bad = 1'b1;
      endcase
   end

   // Slot timing and shifting: load a fresh symbol at the boundary, otherwise move one bit toward the output end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg        <= 10'd0;
         bit_cnt      <= 4'd9;
         tx_sym_start <= 1'b0;
      end else if (boundary) begin
         shreg        <= load_sym;
         bit_cnt      <= 4'd0;
         tx_sym_start <= 1'b1;
      end else begin
         if (MSB_FIRST) begin
            shreg <= {shreg[8:0], 1'b0};
         end else begin
            shreg <= {1'b0, shreg[9:1]};
         end
         bit_cnt      <= bit_cnt + 4'd1;
         tx_sym_start <= 1'b0;
      end
   end

   // Holding register: a boundary with a full hold drains it (ready is low so no write can collide), otherwise a handshake fills it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold      <= 10'd0;
         hold_full <= 1'b0;
      end else if (boundary && hold_full) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         hold      <= sym_in;
         hold_full <= 1'b1;
      end
   end

   // Slot status: disparity, idle flag and illegal-symbol pulse all change on the load edge only
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd          <= 1'b0;
         idle_active <= 1'b0;
         sym_err     <= 1'b0;
      end else if (boundary) begin
         rd          <= rd_next;
         idle_active <= ~hold_full;
         sym_err     <= hold_full & load_bad;
      end else begin
         sym_err     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tx_serializer_10b.sv
`timescale 1ns/1ps
// tb_tx_serializer_10b
// Self-checking bench for tx_serializer_10b. A monitor reassembles every
// ten-bit slot from the line and checks it against a scoreboard queue of
// written symbols, or against the expected comma when the slot is idle.
module tb_tx_serializer_10b;

   localparam logic [9:0] COMMA_NEG_V = 10'b0011111010;
   localparam logic [9:0] COMMA_POS_V = 10'b1100000101;
   localparam logic [1:0] RD_NEG  = 2'd0;
   localparam logic [1:0] RD_POS  = 2'd1;
   localparam logic [1:0] RD_KEEP = 2'd2;

   typedef struct {
      logic [9:0] sym;
      logic [1:0] rd_mode;
      logic       err;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [9:0] sym_in;
   logic       sym_valid;
   logic       sym_ready;
   logic       tx_serial;
   logic       tx_sym_start;
   logic       idle_active;
   logic       rd_pos;
   logic       sym_err;

   logic       lsb_valid;
   logic       lsb_ready;
   logic       lsb_serial;
   logic       lsb_start;
   logic       lsb_idle;
   logic       lsb_rd;
   logic       lsb_err;

   int   checks;
   int   errors;
   bit   mon_en;
   logic model_rd;
   int   slot_count;
   int   idle_count;
   int   data_slots[$];
   vec_t exp_q[$];

   tx_serializer_10b u_dut (
      .clk          (clk),
      .rst          (rst),
      .sym_in       (sym_in),
      .sym_valid    (sym_valid),
      .sym_ready    (sym_ready),
      .tx_serial    (tx_serial),
      .tx_sym_start (tx_sym_start),
      .idle_active  (idle_active),
      .rd_pos       (rd_pos),
      .sym_err      (sym_err)
   );

   tx_serializer_10b #(.MSB_FIRST(1'b0)) u_lsb (
      .clk          (clk),
      .rst          (rst),
      .sym_in       (sym_in),
      .sym_valid    (lsb_valid),
      .sym_ready    (lsb_ready),
      .tx_serial    (lsb_serial),
      .tx_sym_start (lsb_start),
      .idle_active  (lsb_idle),
      .rd_pos       (lsb_rd),
      .sym_err      (lsb_err)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0b, required %0b (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: required event or record not present (t=%0t)", name, $time);
   endtask

   // Handshake one symbol; called and returns on a falling edge
   task automatic applyStimulus(input logic [9:0] sym, input logic [1:0] rd_mode, input logic err, output int stalls);
      vec_t e;
      sym_in    = sym;
      sym_valid = 1'b1;
      stalls    = 0;
      while (!sym_ready && stalls < 40) begin
         @(negedge clk);
         stalls++;
      end
      if (!sym_ready) begin
         failNow("handshake_timeout");
         sym_valid = 1'b0;
         return;
      end
      e.sym     = sym;
      e.rd_mode = rd_mode;
      e.err     = err;
      exp_q.push_back(e);
      @(negedge clk);
      sym_valid = 1'b0;
   endtask

   task automatic waitStart();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tx_sym_start && n < 30);
      if (!tx_sym_start) failNow("start_timeout");
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) failNow("drain_timeout");
   endtask

   // Slot monitor: rebuild each slot from the line and score it
   initial begin : monitor
      int         bit_i;
      logic [9:0] line;
      logic       slot_idle;
      logic       slot_rd;
      logic       slot_err;
      bit         in_slot;
      vec_t       e;
      logic [9:0] exp_comma;
      logic       exp_rd;
      bit_i     = 0;
      line      = '0;
      slot_idle = 1'b0;
      slot_rd   = 1'b0;
      slot_err  = 1'b0;
      in_slot   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || !mon_en) begin
            in_slot = 1'b0;
         end else if (tx_sym_start) begin
            if (in_slot) checkOutput("slot_period", bit_i, 10);
            line      = {9'b0, tx_serial};
            bit_i     = 1;
            slot_idle = idle_active;
            slot_rd   = rd_pos;
            slot_err  = sym_err;
            in_slot   = 1'b1;
         end else if (in_slot) begin
            if (bit_i == 10) begin
               checkOutput("slot_period_start", tx_sym_start, 1'b1);
               in_slot = 1'b0;
            end else begin
               if (bit_i == 1) checkOutput("err_one_cycle", sym_err, 1'b0);
               line = {line[8:0], tx_serial};
               bit_i++;
               if (bit_i == 10) begin
                  if (slot_idle) begin
                     exp_comma = model_rd ? COMMA_POS_V : COMMA_NEG_V;
                     checkOutput("idle_symbol", line, exp_comma);
                     model_rd = ~model_rd;
                     checkOutput("idle_rd_pos", slot_rd, model_rd);
                     checkOutput("idle_sym_err", slot_err, 1'b0);
                     idle_count++;
                  end else if (exp_q.size() == 0) begin
                     failNow("unexpected_data_slot");
                  end else begin
                     e = exp_q.pop_front();
                     checkOutput("data_symbol", line, e.sym);
                     exp_rd = (e.rd_mode == RD_KEEP) ? model_rd : e.rd_mode[0];
                     checkOutput("data_rd_pos", slot_rd, exp_rd);
                     checkOutput("data_sym_err", slot_err, e.err);
                     model_rd = exp_rd;
                     data_slots.push_back(slot_count);
                  end
                  slot_count++;
               end
            end
         end
      end
   end

   // Watchdog so the run always reaches a summary
   initial begin : watchdog
      #200000;
      failNow("global_timeout");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Main sequence
   initial begin : main
      vec_t       vecs [13];
      int         s1;
      int         s2;
      int         s3;
      int         n0;
      int         nd;
      logic [9:0] lsb_line;

      checks     = 0;
      errors     = 0;
      mon_en     = 1'b0;
      model_rd   = 1'b0;
      slot_count = 0;
      idle_count = 0;
      rst        = 1'b1;
      sym_in     = 10'd0;
      sym_valid  = 1'b0;
      lsb_valid  = 1'b0;

      vecs[0]  = '{10'b1001110100, RD_KEEP, 1'b0};
      vecs[1]  = '{10'b0110001011, RD_KEEP, 1'b0};
      vecs[2]  = '{10'b1111111000, RD_KEEP, 1'b1};
      vecs[3]  = '{10'b1110100011, RD_POS,  1'b0};
      vecs[4]  = '{10'b0001011100, RD_NEG,  1'b0};
      vecs[5]  = '{10'b0000000000, RD_KEEP, 1'b1};
      vecs[6]  = '{10'b1111110000, RD_POS,  1'b0};
      vecs[7]  = '{10'b1111111111, RD_KEEP, 1'b1};
      vecs[8]  = '{10'b0000001111, RD_NEG,  1'b0};
      vecs[9]  = '{10'b1010101010, RD_KEEP, 1'b0};
      vecs[10] = '{10'b1000000000, RD_KEEP, 1'b1};
      vecs[11] = '{10'b0011111010, RD_POS,  1'b0};
      vecs[12] = '{10'b0111111111, RD_KEEP, 1'b1};

      $display("[TB] reset state");
      repeat (3) @(negedge clk);
      checkOutput("rst_tx_serial", tx_serial, 1'b0);
      checkOutput("rst_sym_start", tx_sym_start, 1'b0);
      checkOutput("rst_idle", idle_active, 1'b0);
      checkOutput("rst_rd_pos", rd_pos, 1'b0);
      checkOutput("rst_sym_err", sym_err, 1'b0);
      checkOutput("rst_ready", sym_ready, 1'b1);
      sym_in    = 10'b1111110000;
      sym_valid = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_ignores_handshake", sym_ready, 1'b1);
      sym_valid = 1'b0;
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      $display("[TB] idle commas after release");
      @(negedge clk);
      checkOutput("first_boundary", tx_sym_start, 1'b1);
      checkOutput("first_idle", idle_active, 1'b1);
      checkOutput("lsb_first_boundary", lsb_start, 1'b1);
      lsb_line = {9'b0, lsb_serial};
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         lsb_line = {lsb_line[8:0], lsb_serial};
      end
      checkOutput("lsb_first_comma", lsb_line, 10'b0101111100);
      checkOutput("lsb_rd_after_comma", lsb_rd, 1'b1);
      checkOutput("lsb_idle", lsb_idle, 1'b1);
      checkOutput("lsb_ready", lsb_ready, 1'b1);
      checkOutput("lsb_err", lsb_err, 1'b0);
      repeat (40) @(negedge clk);
      checkOutput("idle_slots_seen", idle_count >= 4, 1'b1);

      $display("[TB] single write at a boundary edge");
      waitStart();
      repeat (9) @(negedge clk);
      sym_in    = 10'b1001110100;
      sym_valid = 1'b1;
      exp_q.push_back('{10'b1001110100, RD_KEEP, 1'b0});
      @(negedge clk);
      sym_valid = 1'b0;
      checkOutput("boundary_start", tx_sym_start, 1'b1);
      checkOutput("no_bypass", idle_active, 1'b1);
      checkOutput("hold_full_ready", sym_ready, 1'b0);
      repeat (10) @(negedge clk);
      checkOutput("data_slot_start", tx_sym_start, 1'b1);
      checkOutput("data_slot_not_idle", idle_active, 1'b0);
      checkOutput("ready_after_load", sym_ready, 1'b1);
      waitDrain();

      $display("[TB] back-to-back writes");
      n0 = data_slots.size();
      applyStimulus(10'b1001110100, RD_KEEP, 1'b0, s1);
      applyStimulus(10'b1001110100, RD_KEEP, 1'b0, s2);
      applyStimulus(10'b1001110100, RD_KEEP, 1'b0, s3);
      checkOutput("b2b_stall", s2 > 0, 1'b1);
      waitDrain();
      if (data_slots.size() < n0 + 3) begin
         failNow("b2b_slots_missing");
      end else begin
         checkOutput("b2b_no_comma", data_slots[n0 + 2] - data_slots[n0], 2);
      end

      $display("[TB] vector table");
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].sym, vecs[i].rd_mode, vecs[i].err, s1);
      end
      waitDrain();

      $display("[TB] reset in the middle of a data slot");
      applyStimulus(10'b1111110000, RD_POS, 1'b0, s1);
      applyStimulus(10'b0110001011, RD_KEEP, 1'b0, s2);
      mon_en = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("pre_reset_hold_full", sym_ready, 1'b0);
      checkOutput("pre_reset_rd_pos", rd_pos, 1'b1);
      checkOutput("pre_reset_line", tx_serial, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_tx_serial", tx_serial, 1'b0);
      checkOutput("mid_rst_rd_pos", rd_pos, 1'b0);
      checkOutput("mid_rst_idle", idle_active, 1'b0);
      checkOutput("mid_rst_sym_start", tx_sym_start, 1'b0);
      checkOutput("mid_rst_sym_err", sym_err, 1'b0);
      checkOutput("mid_rst_ready", sym_ready, 1'b1);
      exp_q.delete();
      model_rd = 1'b0;
      nd = data_slots.size();
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_start", tx_sym_start, 1'b1);
      checkOutput("post_rst_idle", idle_active, 1'b1);
      repeat (30) @(negedge clk);
      checkOutput("held_never_sent", data_slots.size(), nd);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tx_serializer_10b.md
Name: tx_serializer_10b

Overview:
- Downstream consumer of the 8b/10b encoder output.
- Accepts one 10-bit encoded symbol at a time through a valid/ready handshake and shifts it out serially, one bit per clock.
- Fills idle slots with K28.5 comma symbols, choosing the comma variant from the running disparity it tracks on the transmitted stream.
- Forms the parallel-to-line boundary of the transmit path.

Parameters:
- COMMA_NEG, 10'b0011111010, K28.5 sent when running disparity is negative (abcdei fghj, a = bit 9).
- COMMA_POS, 10'b1100000101, K28.5 sent when running disparity is positive.
- MSB_FIRST, 1, 1 = bit 9 (a) transmitted first; 0 = bit 0 first.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sym_in  input  10  encoded symbol (abcdei = [9:4], fghj = [3:0]).
- sym_valid  input  1  sym_in valid.
- sym_ready  output  1  holding register empty; transfer on sym_valid & sym_ready at a clock edge.
- tx_serial  output  1  serial line bit.
- tx_sym_start  output  1  high during the cycle tx_serial carries bit 0 of a symbol slot.
- idle_active  output  1  high for the whole slot when the current slot carries a comma.
- rd_pos  output  1  running disparity after the current slot's symbol (1 = positive).
- sym_err  output  1  one-cycle pulse when a loaded data symbol has a ones-count other than 4, 5 or 6.

Behaviour:
- Reset values (asynchronous): shift register 0, bit_cnt = 9, hold empty, rd = negative.
  - Outputs under reset: tx_serial = 0, tx_sym_start = 0, idle_active = 0, rd_pos = 0, sym_err = 0, sym_ready = 1.
  - While rst is high, handshakes are ignored.
- Holding register:
  - Single entry. sym_ready = !hold_full, combinational from the register.
  - Accepted sym_in is stored in hold; hold_full is set.
  - No bypass: a symbol accepted at a boundary edge is transmitted in the following slot, not the current one.
- Slot timing:
  - bit_cnt counts 0..9 and wraps 9 -> 0.
  - A boundary is the edge where bit_cnt == 9. The first edge after reset release is a boundary.
- At the boundary edge:
  - If hold_full: load hold into the shift register, clear hold_full, idle_active <= 0.
  - Else: load COMMA_NEG if rd is negative, COMMA_POS if positive; idle_active <= 1.
  - tx_sym_start <= 1 for the next cycle.
- Shifting:
  - Each non-boundary edge shifts by one toward the output end.
  - tx_serial = shreg[9] if MSB_FIRST, else shreg[0].
  - A slot is exactly 10 cycles. Latency from acceptance into an empty hold to first bit on the line: up to 10 cycles, until the next boundary + 1.
- Running disparity, updated at the load edge from the loaded symbol's ones count n:
  - n = 6 -> positive.
  - n = 4 -> negative.
  - n = 5 -> unchanged.
  - Any other n -> rd unchanged, sym_err pulses for one cycle. The symbol is still transmitted.
  - Commas always have n = 6 or 4, so consecutive idles alternate COMMA_NEG/COMMA_POS.
- rd_pos reflects the rd register, updated in the same edge as the load.
- Simultaneous events: a handshake and a boundary on the same edge cannot both involve hold.
  - If hold is full, ready = 0, so no write occurs.
  - If hold is empty, the write fills hold and the boundary loads a comma.
- Reset mid-slot: the partial symbol is dropped, hold is discarded, and rd returns to negative. The first slot after reset is COMMA_NEG.

Test Plan:
- Reset release, no traffic -> slots alternate 0011111010 / 1100000101 (MSB first); idle_active = 1; rd_pos toggles 1, 0, 1 at each boundary; tx_sym_start every 10th cycle.
- Write 10'b1001110100 (D0.0, RD-, n = 5) while idle at rd negative -> sent in the next slot after hold loads; bits 1,0,0,1,1,1,0,1,0,0; rd_pos stays 0; sym_ready returns to 1 at the boundary edge.
- Back-to-back writes of D0.0, D0.0, D0.0 with sym_valid held high -> second write stalls (sym_ready = 0) until the boundary; 30 consecutive line bits carry the three symbols with no comma between them.
- Write 10'b1111111000 (n = 7) -> transmitted unchanged; sym_err pulses for exactly one cycle at the load; rd_pos unchanged.
- Assert rst at bit 4 of a data slot with hold full -> all outputs 0 immediately; after release, first slot is COMMA_NEG; the held symbol is never sent.
- MSB_FIRST = 0, idle -> line order of first comma is 0,1,0,1,1,1,1,1,0,0.
